// File: rtl/chip8_video_pkg.sv
// ---------------------------------------------------------------------------
// chip8_video_pkg
// Shared definitions for the CHIP-8 video path: framebuffer geometry, the
// byte-addressing rule used by both the sprite drawer and the VGA scan-out,
// and the sprite drawer's state encoding.
//
// Framebuffer layout: pixel (px,py) lives in bit px%8 of byte
// py*FB_BYTES_PER_ROW + px/8, with bit 0 being the leftmost pixel of the byte.
// ---------------------------------------------------------------------------
package chip8_video_pkg;

  localparam int FB_WIDTH         = 64;
  localparam int FB_HEIGHT        = 32;
  localparam int FB_BYTES_PER_ROW = FB_WIDTH / 8;
  localparam int FB_ADDR_W        = 8;

  // Number of pixels packed into one framebuffer byte and the pixel-index
  // bits that select a bit inside that byte.
  localparam int PIXELS_PER_BYTE  = 8;
  localparam int PIXEL_BIT_W      = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SPR_RD,
    ST_SPR_LATCH,
    ST_FB0_RD,
    ST_FB0_WR,
    ST_FB1_RD,
    ST_FB1_WR,
    ST_ROW_NEXT,
    ST_DONE
  } draw_state_e;

  // Byte address of framebuffer column byte 'col' on pixel row 'row'.
  function automatic logic [FB_ADDR_W-1:0] fb_byte_addr(input logic [7:0] row,
                                                        input logic [7:0] col);
    return FB_ADDR_W'(int'(row) * FB_BYTES_PER_ROW + int'(col));
  endfunction

endpackage

// File: rtl/sprite_row_align.sv
// ---------------------------------------------------------------------------
// sprite_row_align
// Turns one sprite byte into the two framebuffer XOR masks it touches.
// Sprite bytes are MSB-leftmost while framebuffer bytes are LSB-leftmost, so
// the byte is bit-reversed first and then shifted left by the pixel offset
// inside the first framebuffer byte; the bits that overflow land in the next
// framebuffer byte.
//
// Ports:
//   sprite_byte  in  8  sprite row as fetched from main memory
//   shift        in  3  x0 % 8
//   mask0        out 8  XOR mask for framebuffer byte col0
//   mask1        out 8  XOR mask for framebuffer byte col0+1 (0 when shift=0)
// ---------------------------------------------------------------------------
module sprite_row_align
  import chip8_video_pkg::*;
(
  input  logic [7:0]             sprite_byte,
  input  logic [PIXEL_BIT_W-1:0] shift,
  output logic [7:0]             mask0,
  output logic [7:0]             mask1
);

  logic [7:0]  rev;
  logic [15:0] wide;

  always_comb begin
    for (int b = 0; b < PIXELS_PER_BYTE; b++) begin
      rev[b] = sprite_byte[7-b];
    end
    // Upper half of the widened shift equals rev >> (8 - shift).
    wide  = {8'd0, rev} << shift;
    mask0 = wide[7:0];
    mask1 = wide[15:8];
  end

endmodule

// File: rtl/sprite_draw.sv
// ---------------------------------------------------------------------------
// sprite_draw
// CHIP-8 DXYN executor. Fetches N sprite rows from main memory starting at I
// and XORs them into the 64x32 framebuffer through read-modify-write cycles,
// reporting whether any lit pixel was turned off (VF). Owns the framebuffer
// write port; scan-out uses the other port of the dual-port RAM.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           1-cycle request, only honoured in IDLE
//   x, y, n         sprite position (Vx, Vy) and height in rows
//   i_addr          sprite base address (I)
//   busy / done     busy from the cycle after start through done; done pulses
//   collision       VF result, valid at done, held until the next start
//   mem_read/addr   main memory read port, mem_data valid one cycle later
//   fb_read/write   framebuffer strobes, fb_addr byte address, fb_wdata data
//   fb_rdata        framebuffer read data, valid one cycle after fb_read
// ---------------------------------------------------------------------------
module sprite_draw
  import chip8_video_pkg::*;
#(
  parameter int FB_WIDTH   = 64,
  parameter int FB_HEIGHT  = 32,
  parameter int MEM_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            x,
  input  logic [7:0]            y,
  input  logic [3:0]            n,
  input  logic [MEM_ADDR_W-1:0] i_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  collision,
  output logic                  mem_read,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [7:0]            mem_data,
  output logic                  fb_read,
  output logic                  fb_write,
  output logic [FB_ADDR_W-1:0]  fb_addr,
  output logic [7:0]            fb_wdata,
  input  logic [7:0]            fb_rdata
);

  localparam int X_W   = $clog2(FB_WIDTH);
  localparam int Y_W   = $clog2(FB_HEIGHT);
  localparam int COL_W = X_W - PIXEL_BIT_W;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(FB_WIDTH / PIXELS_PER_BYTE - 1);

  draw_state_e           state_q, state_d;
  logic [X_W-1:0]        x0_q, x0_d;
  logic [Y_W-1:0]        y0_q, y0_d;
  logic [3:0]            n_q, n_d;
  logic [MEM_ADDR_W-1:0] i_q, i_d;
  logic [4:0]            row_q, row_d;
  logic [7:0]            mask0_q, mask0_d;
  logic [7:0]            mask1_q, mask1_d;
  logic                  wsel_q, wsel_d;
  logic                  collision_q, collision_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mem_read_q, mem_read_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic                  fb_read_q, fb_read_d;
  logic                  fb_write_q, fb_write_d;
  logic [FB_ADDR_W-1:0]  fb_addr_q, fb_addr_d;

  logic [PIXEL_BIT_W-1:0] shift;
  logic [COL_W-1:0]       col0;
  logic [7:0]             align_m0, align_m1;
  logic [4:0]             next_row;
  logic [7:0]             line_y;
  logic [7:0]             next_line_y;
  logic [7:0]             wr_mask;

  assign shift       = x0_q[PIXEL_BIT_W-1:0];
  assign col0        = x0_q[X_W-1:PIXEL_BIT_W];
  assign next_row    = row_q + 5'd1;
  assign line_y      = 8'(y0_q) + 8'(row_q);
  assign next_line_y = 8'(y0_q) + 8'(next_row);
  assign wr_mask     = wsel_q ? mask1_q : mask0_q;

  sprite_row_align u_align (
    .sprite_byte (mem_data),
    .shift       (shift),
    .mask0       (align_m0),
    .mask1       (align_m1)
  );

  // Write data has to come straight from the RAM read port: fb_rdata only
  // becomes valid in the write cycle itself, so it cannot be registered first.
  assign fb_wdata  = fb_write_q ? (fb_rdata ^ wr_mask) : 8'd0;

  assign busy      = busy_q;
  assign done      = done_q;
  assign collision = collision_q;
  assign mem_read  = mem_read_q;
  assign mem_addr  = mem_addr_q;
  assign fb_read   = fb_read_q;
  assign fb_write  = fb_write_q;
  assign fb_addr   = fb_addr_q;

  // Next-state logic. Strobes and addresses are decoded for the state being
  // entered so that they come out of flops aligned with that state.
  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    n_d         = n_q;
    i_d         = i_q;
    row_d       = row_q;
    mask0_d     = mask0_q;
    mask1_d     = mask1_q;
    wsel_d      = wsel_q;
    collision_d = collision_q;
    mem_read_d  = 1'b0;
    mem_addr_d  = '0;
    fb_read_d   = 1'b0;
    fb_write_d  = 1'b0;
    fb_addr_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x0_d        = X_W'(32'(x) % FB_WIDTH);
          y0_d        = Y_W'(32'(y) % FB_HEIGHT);
          n_d         = n;
          i_d         = i_addr;
          row_d       = 5'd0;
          collision_d = 1'b0;
          if (n != 4'd0) begin
            state_d    = ST_SPR_RD;
            mem_read_d = 1'b1;
            mem_addr_d = i_addr;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_SPR_RD: begin
        state_d = ST_SPR_LATCH;
      end

      ST_SPR_LATCH: begin
        mask0_d   = align_m0;
        mask1_d   = align_m1;
        state_d   = ST_FB0_RD;
        fb_read_d = 1'b1;
        fb_addr_d = fb_byte_addr(line_y, 8'(col0));
      end

      ST_FB0_RD: begin
        state_d    = ST_FB0_WR;
        fb_write_d = 1'b1;
        fb_addr_d  = fb_addr_q;
        wsel_d     = 1'b0;
      end

      ST_FB0_WR: begin
        collision_d = collision_q | (|(fb_rdata & mask0_q));
        // The second byte is only needed when the sprite straddles a byte
        // boundary and that byte is still on screen.
        if (shift != '0 && col0 != LAST_COL) begin
          state_d   = ST_FB1_RD;
          fb_read_d = 1'b1;
          fb_addr_d = fb_byte_addr(line_y, 8'(col0) + 8'd1);
        end else begin
          state_d = ST_ROW_NEXT;
        end
      end

      ST_FB1_RD: begin
        state_d    = ST_FB1_WR;
        fb_write_d = 1'b1;
        fb_addr_d  = fb_addr_q;
        wsel_d     = 1'b1;
      end

      ST_FB1_WR: begin
        collision_d = collision_q | (|(fb_rdata & mask1_q));
        state_d     = ST_ROW_NEXT;
      end

      ST_ROW_NEXT: begin
        row_d = next_row;
        // Rows below the bottom edge are clipped, so stop fetching there.
        if (next_row == {1'b0, n_q} || next_line_y == 8'(FB_HEIGHT)) begin
          state_d = ST_DONE;
        end else begin
          state_d    = ST_SPR_RD;
          mem_read_d = 1'b1;
          mem_addr_d = i_q + MEM_ADDR_W'(next_row);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      n_q         <= '0;
      i_q         <= '0;
      row_q       <= '0;
      mask0_q     <= '0;
      mask1_q     <= '0;
      wsel_q      <= 1'b0;
      collision_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= '0;
      fb_read_q   <= 1'b0;
      fb_write_q  <= 1'b0;
      fb_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      n_q         <= n_d;
      i_q         <= i_d;
      row_q       <= row_d;
      mask0_q     <= mask0_d;
      mask1_q     <= mask1_d;
      wsel_q      <= wsel_d;
      collision_q <= collision_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_read_q  <= mem_read_d;
      mem_addr_q  <= mem_addr_d;
      fb_read_q   <= fb_read_d;
      fb_write_q  <= fb_write_d;
      fb_addr_q   <= fb_addr_d;
    end
  end

endmodule

// File: tb/tb_sprite_draw.sv
// ---------------------------------------------------------------------------
// tb_sprite_draw
// Bench for sprite_draw. Provides main memory and the framebuffer RAM with
// one-cycle read latency, and keeps a pixel-level reference framebuffer that
// is updated straight from the DXYN rules (wrap the start point, XOR each lit
// sprite pixel, drop anything off the right or bottom edge).
// ---------------------------------------------------------------------------
module tb_sprite_draw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  x = 8'd0;
  logic [7:0]  y = 8'd0;
  logic [3:0]  n = 4'd0;
  logic [11:0] i_addr = 12'd0;
  logic        busy, done, collision;
  logic        mem_read;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        fb_read, fb_write;
  logic [7:0]  fb_addr, fb_wdata, fb_rdata;

  logic [7:0]  mainMem [4096];
  logic [7:0]  fbRam   [256];
  logic [7:0]  modelFb [256];
  logic        clearReq = 1'b0;

  int checks = 0;
  int errors = 0;
  int memReads = 0;
  int fbWrites = 0;
  int protoErrs = 0;

  always #5 clk = ~clk;

  sprite_draw #(
    .FB_WIDTH   (64),
    .FB_HEIGHT  (32),
    .MEM_ADDR_W (12)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x         (x),
    .y         (y),
    .n         (n),
    .i_addr    (i_addr),
    .busy      (busy),
    .done      (done),
    .collision (collision),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .fb_read   (fb_read),
    .fb_write  (fb_write),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .fb_rdata  (fb_rdata)
  );

  // Memories with one-cycle read latency; read data is junk when not reading.
  always @(posedge clk) begin
    mem_data <= mem_read ? mainMem[mem_addr] : 8'($urandom);
    fb_rdata <= fb_read ? fbRam[fb_addr] : 8'($urandom);
    if (clearReq) begin
      for (int a = 0; a < 256; a++) fbRam[a] <= 8'd0;
    end else if (fb_write) begin
      fbRam[fb_addr] <= fb_wdata;
    end
  end

  // Bus monitor: counts accesses and flags strobe/idle-value violations.
  always @(negedge clk) begin
    if (mem_read) memReads++;
    if (fb_write) fbWrites++;
    if (int'(mem_read) + int'(fb_read) + int'(fb_write) > 1) protoErrs++;
    if (!mem_read && mem_addr != 12'd0) protoErrs++;
    if (!fb_read && !fb_write && fb_addr != 8'd0) protoErrs++;
    if (!fb_write && fb_wdata != 8'd0) protoErrs++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference DXYN: applies the draw to modelFb and predicts bus activity.
  task automatic modelDraw(input logic [7:0] xv, input logic [7:0] yv,
                           input logic [3:0] nv, input logic [11:0] iv,
                           output int coll, output int reads,
                           output int writes, output int cycles);
    int x0, y0, py, px, a;
    logic [7:0] spr;
    coll = 0; reads = 0; writes = 0; cycles = 0;
    x0 = int'(xv) % 64;
    y0 = int'(yv) % 32;
    for (int r = 0; r < int'(nv); r++) begin
      py = y0 + r;
      if (py < 32) begin
        reads++;
        writes++;
        cycles += 5;
        if ((x0 % 8) != 0 && (x0 / 8) != 7) begin
          writes++;
          cycles += 2;
        end
        spr = mainMem[12'(int'(iv) + r)];
        for (int b = 0; b < 8; b++) begin
          px = x0 + b;
          if (spr[7-b] && px < 64) begin
            a = py * 8 + px / 8;
            if (modelFb[a][px % 8]) coll = 1;
            modelFb[a][px % 8] = ~modelFb[a][px % 8];
          end
        end
      end
    end
  endtask

  task automatic clearFb();
    @(negedge clk);
    clearReq = 1'b1;
    @(negedge clk);
    clearReq = 1'b0;
    for (int a = 0; a < 256; a++) modelFb[a] = 8'd0;
  endtask

  task automatic compareFb(input string tag);
    int diffs = 0;
    for (int a = 0; a < 256; a++) if (fbRam[a] !== modelFb[a]) diffs++;
    checkOutput(tag, diffs, 0);
  endtask

  // Runs one draw to completion, optionally pulsing start while busy.
  task automatic applyStimulus(input logic [7:0] xv, input logic [7:0] yv,
                               input logic [3:0] nv, input logic [11:0] iv,
                               input bit poke);
    int expColl, expReads, expWrites, expCycles;
    int r0, w0, p0, k;
    modelDraw(xv, yv, nv, iv, expColl, expReads, expWrites, expCycles);
    r0 = memReads; w0 = fbWrites; p0 = protoErrs;
    x = xv; y = yv; n = nv; i_addr = iv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = 8'($urandom); y = 8'($urandom); n = 4'($urandom); i_addr = 12'($urandom);
    checkOutput("busy_rise", busy, 1);
    k = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
      start = (poke && k == 2);
    end
    start = 1'b0;
    checkOutput("done_seen", done, 1);
    checkOutput("latency", k, expCycles);
    checkOutput("collision", collision, expColl);
    @(negedge clk);
    checkOutput("done_pulse", done, 0);
    checkOutput("busy_end", busy, 0);
    checkOutput("coll_hold", collision, expColl);
    checkOutput("mem_reads", memReads - r0, expReads);
    checkOutput("fb_writes", fbWrites - w0, expWrites);
    checkOutput("protocol", protoErrs - p0, 0);
    compareFb("fb_image");
  endtask

  initial begin
    int w0, k;
    for (int a = 0; a < 4096; a++) mainMem[a] = 8'($urandom);
    for (int a = 0; a < 256; a++) modelFb[a] = 8'd0;

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_coll", collision, 0);
    checkOutput("rst_mem_read", mem_read, 0);
    checkOutput("rst_fb_read", fb_read, 0);
    checkOutput("rst_fb_write", fb_write, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_fb_addr", fb_addr, 0);
    checkOutput("rst_fb_wdata", fb_wdata, 0);
    rst_n = 1'b1;
    clearFb();

    // Basic draw, then the same draw again to erase it.
    mainMem[12'h050] = 8'hF0;
    applyStimulus(8'd0, 8'd0, 4'd1, 12'h050, 1'b0);
    checkOutput("t1_fb0", fbRam[0], 8'h0F);
    applyStimulus(8'd0, 8'd0, 4'd1, 12'h050, 1'b0);
    checkOutput("t2_fb0", fbRam[0], 8'h00);
    checkOutput("t2_coll", collision, 1);

    // Zero-height sprite clears the previous collision and does nothing else.
    applyStimulus(8'd5, 8'd5, 4'd0, 12'h123, 1'b0);

    // Straddling two bytes.
    clearFb();
    mainMem[12'h100] = 8'hFF;
    applyStimulus(8'd4, 8'd2, 4'd1, 12'h100, 1'b0);
    checkOutput("t3_fb16", fbRam[16], 8'hF0);
    checkOutput("t3_fb17", fbRam[17], 8'h0F);

    // Bottom-right corner clipping.
    clearFb();
    mainMem[12'h200] = 8'hFF; mainMem[12'h201] = 8'hFF; mainMem[12'h202] = 8'hFF;
    applyStimulus(8'd60, 8'd31, 4'd3, 12'h200, 1'b0);
    checkOutput("t4_fb255", fbRam[255], 8'hF0);

    // Start position wraps.
    clearFb();
    mainMem[12'h300] = 8'h80; mainMem[12'h301] = 8'h80;
    applyStimulus(8'd70, 8'd33, 4'd2, 12'h300, 1'b0);
    checkOutput("t5_fb8", fbRam[8], 8'h40);
    checkOutput("t5_fb16", fbRam[16], 8'h40);

    // Sprite address wraps past the top of memory; start pulsed while busy.
    applyStimulus(8'd16, 8'd10, 4'd3, 12'hFFE, 1'b1);

    // Reset during the first framebuffer read aborts without writing.
    mainMem[12'h400] = 8'hAA;
    x = 8'd8; y = 8'd3; n = 4'd2; i_addr = 12'h400; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!fb_read && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("rst_wait_fb_read", fb_read, 1);
    w0 = fbWrites;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_fb_write", fb_write, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_coll", collision, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("abort_writes", fbWrites - w0, 0);
    compareFb("abort_fb_image");

    // Randomised draws accumulating on the same framebuffer.
    for (int t = 0; t < 40; t++) begin
      logic [3:0] nv;
      nv = 4'($urandom);
      applyStimulus(8'($urandom), 8'($urandom), nv, 12'($urandom),
                    (nv != 4'd0) && ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
